// File: rtl/wb_arbiter_if.sv
// Write-back port bundle: MEM/WB pipeline write, MDU result handshake and
// the registered register-file write produced by wb_arbiter.
interface wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        stall_o;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_cnt_o;

  modport master (
    output pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata,
    input  mdu_ready, stall_o, rf_we, rf_rd, rf_wdata, fifo_cnt_o
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata, mdu_valid, mdu_rd, mdu_wdata,
    output mdu_ready, stall_o, rf_we, rf_rd, rf_wdata, fifo_cnt_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, MDU results queue in a
// 2-entry FIFO, starvation forces a 1-cycle stall. Optional macro WB_WAW_KILL_EN.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.slave   bus
);

  logic [4:0]  r_rd0, r_rd1;
  logic [31:0] r_dat0, r_dat1;
  logic [1:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_rf_we;
  logic [4:0]  r_rf_rd;
  logic [31:0] r_rf_wdata;

  logic        w_stall, w_busy, w_pop, w_push;
  logic        w_kill0, w_kill1, w_keep0, w_keep1;
  logic [4:0]  w_n_rd0, w_n_rd1;
  logic [31:0] w_n_dat0, w_n_dat1;
  logic [1:0]  w_surv, w_n_cnt;
  logic [3:0]  w_n_starve;

  assign w_stall = (r_starve == 4'(STARVE_LIMIT));
  assign w_busy  = !w_stall && bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign w_pop   = !w_busy && (r_cnt != 2'd0);
  // rd=0 results still complete the handshake but are dropped here
  assign w_push  = bus.mdu_valid && (r_cnt != 2'd2) && (bus.mdu_rd != 5'd0);

`ifdef WB_WAW_KILL_EN
  assign w_kill0 = w_busy && (r_rd0 == bus.pipe_rd);
  assign w_kill1 = w_busy && (r_rd1 == bus.pipe_rd);
`else
  assign w_kill0 = 1'b0;
  assign w_kill1 = 1'b0;
`endif

  assign w_keep0 = (r_cnt != 2'd0) && !w_pop && !w_kill0;
  assign w_keep1 = (r_cnt == 2'd2) && !w_kill1;

  // Compact survivors toward the head, then append the new result
  always_comb begin
    w_n_rd0  = r_rd0;
    w_n_dat0 = r_dat0;
    w_n_rd1  = r_rd1;
    w_n_dat1 = r_dat1;
    w_surv   = 2'd0;
    if (w_keep0 && w_keep1) begin
      w_surv = 2'd2;
    end else if (w_keep0) begin
      w_surv = 2'd1;
    end else if (w_keep1) begin
      w_n_rd0  = r_rd1;
      w_n_dat0 = r_dat1;
      w_surv   = 2'd1;
    end
    w_n_cnt = w_surv;
    if (w_push) begin
      if (w_surv == 2'd0) begin
        w_n_rd0  = bus.mdu_rd;
        w_n_dat0 = bus.mdu_wdata;
      end else begin
        w_n_rd1  = bus.mdu_rd;
        w_n_dat1 = bus.mdu_wdata;
      end
      w_n_cnt = w_surv + 2'd1;
    end
  end

  always_comb begin
    w_n_starve = r_starve;
    if (w_pop || (r_cnt == 2'd0))
      w_n_starve = 4'd0;
    else if (w_busy)
      w_n_starve = r_starve + 4'd1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rd0      <= 5'd0;
      r_rd1      <= 5'd0;
      r_dat0     <= 32'd0;
      r_dat1     <= 32'd0;
      r_cnt      <= 2'd0;
      r_starve   <= 4'd0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else begin
      r_rd0    <= w_n_rd0;
      r_rd1    <= w_n_rd1;
      r_dat0   <= w_n_dat0;
      r_dat1   <= w_n_dat1;
      r_cnt    <= w_n_cnt;
      r_starve <= w_n_starve;
      if (w_busy) begin
        r_rf_we    <= 1'b1;
        r_rf_rd    <= bus.pipe_rd;
        r_rf_wdata <= bus.pipe_wdata;
      end else if (w_pop) begin
        r_rf_we    <= 1'b1;
        r_rf_rd    <= r_rd0;
        r_rf_wdata <= r_dat0;
      end else begin
        r_rf_we    <= 1'b0;
      end
    end
  end

  assign bus.mdu_ready  = (r_cnt != 2'd2);
  assign bus.stall_o    = w_stall;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_rd      = r_rf_rd;
  assign bus.rf_wdata   = r_rf_wdata;
  assign bus.fifo_cnt_o = r_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based model of the
// write-port rules, plus directed pipe/MDU/reset scenarios.
module tb_wb_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic        h_pwe, h_mv, h_mpend;
  logic [4:0]  h_prd, h_mrd;
  logic [31:0] h_pd, h_md;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return m_starve == LIMIT;
  endfunction

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_we = 1'b0;
    m_rd = 5'd0;
    m_data = 32'd0;
    h_mpend = 1'b0;
    h_pwe = 1'b0;
  endtask

  task automatic check_all();
    chk("rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
    chk("rf_rd", {27'd0, bus.rf_rd}, {27'd0, m_rd});
    chk("rf_wdata", bus.rf_wdata, m_data);
    chk("fifo_cnt", {30'd0, bus.fifo_cnt_o}, 32'(m_q.size()));
    chk("mdu_ready", {31'd0, bus.mdu_ready}, {31'd0, m_q.size() != 2});
    chk("stall", {31'd0, bus.stall_o}, {31'd0, m_stall()});
  endtask

  // Returns whether the MDU transfer was accepted at the coming edge
  task automatic model_step(output bit acc);
    bit busy;
    int sz;
    ent_t e;
    busy = !m_stall() && bus.pipe_we && (bus.pipe_rd != 5'd0);
    sz = m_q.size();
    acc = bus.mdu_valid && (sz != 2);
    if (busy) begin
      m_we = 1'b1; m_rd = bus.pipe_rd; m_data = bus.pipe_wdata;
    end else if (sz > 0) begin
      e = m_q.pop_front();
      m_we = 1'b1; m_rd = e.rd; m_data = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (sz == 0 || !busy) m_starve = 0;
    else m_starve++;
`ifdef WB_WAW_KILL_EN
    if (busy)
      for (int i = m_q.size() - 1; i >= 0; i--)
        if (m_q[i].rd == bus.pipe_rd) m_q.delete(i);
`endif
    if (acc && bus.mdu_rd != 5'd0) m_q.push_back('{rd: bus.mdu_rd, d: bus.mdu_wdata});
  endtask

  task automatic step_drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bit acc;
    @(negedge clk);
    check_all();
    h_pwe = pwe; h_prd = prd; h_pd = pd;
    h_mv = mv; h_mrd = mrd; h_md = md;
    bus.pipe_we = pwe; bus.pipe_rd = prd; bus.pipe_wdata = pd;
    bus.mdu_valid = mv; bus.mdu_rd = mrd; bus.mdu_wdata = md;
    model_step(acc);
    h_mpend = mv && !acc;
  endtask

  // A stalled pipeline re-presents its write; a refused MDU result is held
  task automatic step_rand(input int p_pipe, input int p_mdu);
    logic pwe, mv;
    logic [4:0] prd, mrd;
    logic [31:0] pd, md;
    if (m_stall()) begin
      pwe = h_pwe; prd = h_prd; pd = h_pd;
    end else begin
      pwe = ($urandom_range(0, 99) < p_pipe); prd = rnd_rd(); pd = $urandom;
    end
    if (h_mpend) begin
      mv = h_mv; mrd = h_mrd; md = h_md;
    end else begin
      mv = ($urandom_range(0, 99) < p_mdu); mrd = rnd_rd(); md = $urandom;
    end
    step_drive(pwe, prd, pd, mv, mrd, md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, {31'd0, bus.rf_we}, 32'd0);
    chk({tag, "_rd"}, {27'd0, bus.rf_rd}, 32'd0);
    chk({tag, "_wdata"}, bus.rf_wdata, 32'd0);
    chk({tag, "_cnt"}, {30'd0, bus.fifo_cnt_o}, 32'd0);
    chk({tag, "_stall"}, {31'd0, bus.stall_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.mdu_ready}, 32'd1);
  endtask

  initial begin
    bus.pipe_we = 1'b0; bus.pipe_rd = 5'd0; bus.pipe_wdata = 32'd0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = 5'd0; bus.mdu_wdata = 32'd0;
    model_reset();
    #3;
    check_reset_vals("por");
    #9 rst_n = 1'b0;

    // pipe-only write
    step_drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle(1);
    chk("pipe_we", {31'd0, bus.rf_we}, 32'd1);
    chk("pipe_rd", {27'd0, bus.rf_rd}, 32'd5);
    chk("pipe_data", bus.rf_wdata, 32'h1234);
    chk("pipe_stall", {31'd0, bus.stall_o}, 32'd0);

    // MDU result into an idle port: queued after 1 edge, written after 2
    step_drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE);
    idle(1);
    chk("mdu_cnt1", {30'd0, bus.fifo_cnt_o}, 32'd1);
    chk("mdu_we_early", {31'd0, bus.rf_we}, 32'd0);
    idle(1);
    chk("mdu_we", {31'd0, bus.rf_we}, 32'd1);
    chk("mdu_rd", {27'd0, bus.rf_rd}, 32'd7);
    chk("mdu_cnt0", {30'd0, bus.fifo_cnt_o}, 32'd0);

    // full FIFO and starvation under a permanently busy pipe
    for (int i = 0; i < 12; i++)
      step_drive(1'b1, 5'd20, 32'(i), (i < 3) || h_mpend,
                 h_mpend ? h_mrd : 5'(i + 1), h_mpend ? h_md : 32'(100 + i));
    idle(4);

    // WAW scenario: queued rd=9, pipe then writes rd=9
    step_drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    step_drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    step_drive(1'b1, 5'd9, 32'h900, 1'b0, 5'd0, 32'd0);
    idle(4);

    for (int ph = 0; ph < 3; ph++)
      for (int i = 0; i < 400; i++)
        step_rand(ph == 0 ? 95 : (ph == 1 ? 60 : 25), ph == 2 ? 90 : 50);

    // reset mid-operation with two queued entries
    begin
      int k;
      k = 0;
      while (m_q.size() != 2 && k < 20) begin
        step_drive(1'b1, 5'd30, $urandom, 1'b1, 5'd1, $urandom);
        k++;
      end
      @(negedge clk);
      check_all();
      chk("fill2", {30'd0, bus.fifo_cnt_o}, 32'd2);
      bus.pipe_we = 1'b0; bus.mdu_valid = 1'b0;
      #2 rst_n = 1'b1;
      #1 check_reset_vals("mid_rst");
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      idle(3);
    end

    for (int i = 0; i < 400; i++) step_rand(70, 60);
    idle(3);
    @(negedge clk);
    check_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning the number of consecutive pipeline-held write-port cycles tolerated while the FIFO is non-empty; legal range 1..15.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous reset, active-high despite the name.
REQ-005 pipe_we  in  1  MEM/WB stage register-write enable.
REQ-006 pipe_rd  in  5  MEM/WB destination register.
REQ-007 pipe_wdata  in  32  MEM/WB write data.
REQ-008 mdu_valid  in  1  multiply/divide unit result valid.
REQ-009 mdu_rd  in  5  MDU destination register.
REQ-010 mdu_wdata  in  32  MDU result data.
REQ-011 mdu_ready  out  1  the block accepts an MDU result this cycle.
REQ-012 stall_o  out  1  freeze request to the pipeline: MEM/WB holds its contents and re-presents them.
REQ-013 rf_we  out  1  register-file write enable, registered.
REQ-014 rf_rd  out  5  register-file write address, registered.
REQ-015 rf_wdata  out  32  register-file write data, registered.
REQ-016 fifo_cnt_o  out  2  number of queued MDU entries (0..2).

Function
REQ-017 The block SHALL contain a 2-entry in-order FIFO for MDU results; an MDU transfer is accepted when mdu_valid=1 and mdu_ready=1 at a rising edge.
REQ-018 mdu_ready SHALL equal (fifo_cnt_o != 2), with no push-through when full, even if a pop occurs in the same cycle.
REQ-019 An accepted MDU transfer with mdu_rd=0 SHALL complete the handshake and be discarded, not queued.
REQ-020 The pipeline slot SHALL be busy when stall_o=0, pipe_we=1 and pipe_rd!=0; otherwise it is free.
REQ-021 Busy slot: the next edge SHALL load rf_we=1, rf_rd=pipe_rd and rf_wdata=pipe_wdata (1-cycle latency), and the FIFO does not pop.
REQ-022 Free slot with FIFO non-empty: the next edge SHALL pop the FIFO head into rf_we/rf_rd/rf_wdata with rf_we=1.
REQ-023 Free slot with FIFO empty: the next edge SHALL load rf_we=0; rf_rd and rf_wdata hold their values.
REQ-024 There SHALL be no FIFO bypass; the minimum latency from an MDU accept to rf_we is 2 edges.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-026 A 4-bit starvation counter SHALL increment on each edge with the slot busy and the FIFO non-empty, and clear on any pop or while the FIFO is empty.
REQ-027 stall_o SHALL equal (counter == STARVE_LIMIT), decoded from registered state.
REQ-028 While stall_o=1, pipe_* inputs SHALL be ignored and the head SHALL pop; the counter then clears, so each stall lasts exactly 1 cycle.

Reset
REQ-029 While rst_n=1: rf_we=0, rf_rd=0, rf_wdata=0, FIFO empty (fifo_cnt_o=0), counter=0, stall_o=0 and mdu_ready=1.
REQ-030 Reset asserted mid-operation SHALL immediately discard all queued entries, with no write issued for them.

Configuration
REQ-031 Macro WB_WAW_KILL_EN defined: on any edge where the pipeline slot is busy, every queued entry with rd == pipe_rd SHALL be invalidated (removed and count reduced) in the same edge, so an older MDU result never overwrites a younger pipeline write; killed entries are never popped.
REQ-032 WB_WAW_KILL_EN undefined: no entry is killed, and write-after-write ordering is the scoreboard's responsibility.

Verification
REQ-033 Pipe only: pipe_we=1, rd=5, data=0x1234 with FIFO empty -> next edge rf_we=1, rf_rd=5, rf_wdata=0x1234; stall_o stays 0.
REQ-034 MDU into idle port: mdu_valid=1, rd=7, data=0xCAFE with pipe_we=0 -> fifo_cnt_o=1 after edge 1; rf_we=1, rf_rd=7 after edge 2; count 0.
REQ-035 Full FIFO: 3 MDU pushes with the pipe busy -> mdu_ready=0 after 2 accepts and the third is held; after drain, writes occur in push order.
REQ-036 Starvation: FIFO=1 entry, pipe busy on every cycle, STARVE_LIMIT=4 -> stall_o=1 for exactly one cycle after 4 busy edges; the head is written that cycle.
REQ-037 WAW kill (WB_WAW_KILL_EN): queued rd=9, pipe writes rd=9 -> fifo_cnt_o drops to 0 and no rf write to 9 follows. Without the macro, the rd=9 MDU write follows later.
REQ-038 Reset with 2 queued entries -> fifo_cnt_o=0 and rf_we=0 immediately; no queued write appears after release.
